// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: opcodes, ALU control selects and branch funct3 codes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_I1  = 7'b0010011;
    localparam logic [6:0] OP_I2  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam logic [6:0] OP_UPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; shifts use b[4:0], undefined selects yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   alu_ctrl,
    output logic [W-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (alu_ctrl)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = W'($signed(a) < $signed(b));
            ALU_SLTU: y = W'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = W'($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution and EX/MEM pipeline registers.
// Redirect and compare flags are combinational so IF can react this cycle.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            read_data_valid,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] immOut,
    input  logic [XLEN-1:0] Read1,
    input  logic [XLEN-1:0] Read2,
    input  logic [4:0]      rd,
    input  logic [2:0]      func3,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] DataStore,
    output logic            PC_src,
    output logic            jalr,
    output logic            lt,
    output logic            ltu,
    output logic [XLEN-1:0] immOut_EX,
    output logic [XLEN-1:0] PC_EX
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] result_d;
    logic            taken;
    logic            is_br;
    logic            is_j;
    logic            is_jr;
    logic            unused_rd;

    // rd travels alongside in ID/WB; EX has no use for it
    assign unused_rd = ^rd;

    assign is_br = (opcode == OP_BR);
    assign is_j  = (opcode == OP_J);
    assign is_jr = (opcode == OP_JR);

    assign op_a = (opcode == OP_UPC) ? PC : Read1;

    always_comb begin
        op_b = Read2;
        case (opcode)
            OP_I1, OP_I2, OP_S, OP_JR, OP_UPC: op_b = immOut;
            default:                           op_b = Read2;
        endcase
    end

    alu #(.W(XLEN)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_ctrl (alu_ctrl),
        .y        (alu_y)
    );

    assign lt   = ($signed(Read1) < $signed(Read2));
    assign ltu  = (Read1 < Read2);
    assign jalr = is_jr;

    // Branch condition is independent of the ALU select
    always_comb begin
        taken = 1'b0;
        case (func3)
            F3_BEQ:  taken = (Read1 == Read2);
            F3_BNE:  taken = (Read1 != Read2);
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign PC_src = read_data_valid & ((is_br & taken) | is_j | is_jr);

    always_comb begin
        result_d = alu_y;
        if (is_j || is_jr) begin
            result_d = PC + XLEN'(4);
        end else if (opcode == OP_U) begin
            result_d = immOut;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            DataStore <= '0;
            immOut_EX <= '0;
            PC_EX     <= '0;
        end else if (read_data_valid) begin
            result    <= result_d;
            DataStore <= Read2;
            immOut_EX <= immOut;
            PC_EX     <= PC;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed vector bench for ex_stage: table of single-cycle ops plus stall/reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_data_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] immOut;
    logic [31:0] Read1;
    logic [31:0] Read2;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [6:0]  opcode;
    logic [31:0] PC;
    logic [31:0] result;
    logic [31:0] DataStore;
    logic        PC_src;
    logic        jalr;
    logic        lt;
    logic        ltu;
    logic [31:0] immOut_EX;
    logic [31:0] PC_EX;

    int checks = 0;
    int failures = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .read_data_valid (read_data_valid),
        .alu_ctrl        (alu_ctrl),
        .immOut          (immOut),
        .Read1           (Read1),
        .Read2           (Read2),
        .rd              (rd),
        .func3           (func3),
        .opcode          (opcode),
        .PC              (PC),
        .result          (result),
        .DataStore       (DataStore),
        .PC_src          (PC_src),
        .jalr            (jalr),
        .lt              (lt),
        .ltu             (ltu),
        .immOut_EX       (immOut_EX),
        .PC_EX           (PC_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [3:0]  ctrl;
        logic [2:0]  f3;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic        exp_src;
        logic        exp_jalr;
        logic        exp_lt;
        logic        exp_ltu;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] op, input logic [3:0] ctrl,
                                input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] res,
                                input logic src, input logic jl, input logic l, input logic lu);
        vec_t v;
        v.name = name; v.op = op; v.ctrl = ctrl; v.f3 = f3;
        v.r1 = r1; v.r2 = r2; v.imm = imm; v.pc = pc;
        v.exp_res = res; v.exp_src = src; v.exp_jalr = jl; v.exp_lt = l; v.exp_ltu = lu;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        opcode = v.op; alu_ctrl = v.ctrl; func3 = v.f3;
        Read1 = v.r1; Read2 = v.r2; immOut = v.imm; PC = v.pc;
        read_data_valid = valid;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] res, input logic [31:0] ds,
                            input logic [31:0] imm, input logic [31:0] pc);
        chk({tag, ".result"},    result,    res);
        chk({tag, ".DataStore"}, DataStore, ds);
        chk({tag, ".immOut_EX"}, immOut_EX, imm);
        chk({tag, ".PC_EX"},     PC_EX,     pc);
    endtask

    initial begin
        vec_t v;
        // name, opcode, ctrl, f3, Read1, Read2, imm, PC, result, PC_src, jalr, lt, ltu
        vecs.push_back(mk("r_add",   7'b0110011, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10F0, 0, 0, 1, 1));
        vecs.push_back(mk("i_add",   7'b0010011, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h300, 0, 0, 1, 1));
        vecs.push_back(mk("bne_add", 7'b1100011, 4'b0000, 3'b001, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10F0, 1, 0, 1, 1));
        vecs.push_back(mk("bne_sub", 7'b1100011, 4'b0001, 3'b001, 32'h100, 32'hff0, 32'h200, 32'hc, 32'hFFFFF110, 1, 0, 1, 1));
        vecs.push_back(mk("beq_nt",  7'b1100011, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10F0, 0, 0, 1, 1));
        vecs.push_back(mk("jal",     7'b1101111, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10, 1, 0, 1, 1));
        vecs.push_back(mk("jalr",    7'b1100111, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10, 1, 1, 1, 1));
        vecs.push_back(mk("r_sll",   7'b0110011, 4'b0010, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h01000000, 0, 0, 1, 1));
        vecs.push_back(mk("r_sra",   7'b0110011, 4'b0111, 3'b000, 32'h80000000, 32'h4, 32'h200, 32'hc, 32'hF8000000, 0, 0, 1, 0));
        vecs.push_back(mk("r_srl",   7'b0110011, 4'b0110, 3'b000, 32'h80000000, 32'h4, 32'h200, 32'hc, 32'h08000000, 0, 0, 1, 0));
        vecs.push_back(mk("r_slt",   7'b0110011, 4'b0011, 3'b000, 32'h80000000, 32'h4, 32'h200, 32'hc, 32'h1, 0, 0, 1, 0));
        vecs.push_back(mk("r_sltu",  7'b0110011, 4'b0100, 3'b000, 32'h80000000, 32'h4, 32'h200, 32'hc, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk("r_xor",   7'b0110011, 4'b0101, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'hef0, 0, 0, 1, 1));
        vecs.push_back(mk("r_or",    7'b0110011, 4'b1000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'hff0, 0, 0, 1, 1));
        vecs.push_back(mk("r_and",   7'b0110011, 4'b1001, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h100, 0, 0, 1, 1));
        vecs.push_back(mk("r_bad",   7'b0110011, 4'b1010, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h0, 0, 0, 1, 1));
        vecs.push_back(mk("i_sltu",  7'b0010011, 4'b0100, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h1, 0, 0, 1, 1));
        vecs.push_back(mk("lui",     7'b0110111, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h200, 0, 0, 1, 1));
        vecs.push_back(mk("auipc",   7'b0010111, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h20c, 0, 0, 1, 1));
        vecs.push_back(mk("store",   7'b0100011, 4'b0000, 3'b010, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h300, 0, 0, 1, 1));
        vecs.push_back(mk("unk_op",  7'b1111111, 4'b0000, 3'b000, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10F0, 0, 0, 1, 1));
        vecs.push_back(mk("blt_t",   7'b1100011, 4'b0000, 3'b100, 32'h80000000, 32'h4, 32'h0, 32'h40, 32'h80000004, 1, 0, 1, 0));
        vecs.push_back(mk("bge_nt",  7'b1100011, 4'b0000, 3'b101, 32'h80000000, 32'h4, 32'h0, 32'h40, 32'h80000004, 0, 0, 1, 0));
        vecs.push_back(mk("bltu_nt", 7'b1100011, 4'b0000, 3'b110, 32'h80000000, 32'h4, 32'h0, 32'h40, 32'h80000004, 0, 0, 1, 0));
        vecs.push_back(mk("bgeu_t",  7'b1100011, 4'b0000, 3'b111, 32'h80000000, 32'h4, 32'h0, 32'h40, 32'h80000004, 1, 0, 1, 0));
        vecs.push_back(mk("br_f010", 7'b1100011, 4'b0000, 3'b010, 32'h100, 32'hff0, 32'h200, 32'hc, 32'h10F0, 0, 0, 1, 1));
        vecs.push_back(mk("beq_t",   7'b1100011, 4'b0000, 3'b000, 32'h55, 32'h55, 32'h8, 32'h20, 32'hAA, 1, 0, 0, 0));

        rd = 5'd3;
        rst = 1'b1;
        drive(vecs[0], 1'b1);
        @(posedge clk); #1;
        chk_regs("reset", 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v, 1'b1);
            #1;
            chk({v.name, ".PC_src"}, 32'(PC_src), 32'(v.exp_src));
            chk({v.name, ".jalr"},   32'(jalr),   32'(v.exp_jalr));
            chk({v.name, ".lt"},     32'(lt),     32'(v.exp_lt));
            chk({v.name, ".ltu"},    32'(ltu),    32'(v.exp_ltu));
            @(posedge clk); #1;
            chk_regs(v.name, v.exp_res, v.r2, v.imm, v.pc);
        end

        // Known state before stalling: R-type ADD with default operands
        drive(vecs[0], 1'b1);
        @(posedge clk); #1;
        chk_regs("pre_stall", 32'h10F0, 32'hff0, 32'h200, 32'hc);

        // Stall with a JAL and a taken branch presented: no redirect, registers hold
        drive(vecs[5], 1'b0);
        #1;
        chk("stall_jal.PC_src", 32'(PC_src), 32'h0);
        @(posedge clk); #1;
        chk_regs("stall_jal", 32'h10F0, 32'hff0, 32'h200, 32'hc);
        drive(vecs[26], 1'b0);
        #1;
        chk("stall_beq.PC_src", 32'(PC_src), 32'h0);
        @(posedge clk); #1;
        chk_regs("stall_beq", 32'h10F0, 32'hff0, 32'h200, 32'hc);

        // Reset wins while stalled
        rst = 1'b1;
        @(posedge clk); #1;
        chk_regs("stall_rst", 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset also wins over a valid instruction
        drive(vecs[1], 1'b1);
        @(posedge clk); #1;
        chk_regs("rst_valid", 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;

        // Recovery: next valid instruction lands after one edge
        @(posedge clk); #1;
        chk_regs("recover", 32'h300, 32'hff0, 32'h200, 32'hc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage pipelined RV32I core; sits between ID and MEM.
- Performs the ALU operation and resolves conditional and unconditional branches.
- Registers the EX/MEM results: ALU result, store data, immediate and PC.
- Branch-decision outputs are combinational so IF can redirect in the same cycle.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- read_data_valid  in  1  stage enable. 1 = advance; 0 = stall (hold registers, suppress redirect).
- alu_ctrl  in  4  ALU operation select (encoding below).
- immOut  in  32  sign-extended immediate from ID.
- Read1  in  32  rs1 value.
- Read2  in  32  rs2 value.
- rd  in  5  destination register. Accepted for interface compatibility; not used in EX.
- func3  in  3  instruction funct3; branch condition select.
- opcode  in  7  instruction opcode.
- PC  in  32  PC of the instruction in EX.
- result  out  32  registered ALU/link result.
- DataStore  out  32  registered store data (Read2).
- PC_src  out  1  combinational redirect request.
- jalr  out  1  combinational; 1 when opcode = JALR.
- lt  out  1  combinational; signed Read1 < Read2.
- ltu  out  1  combinational; unsigned Read1 < Read2.
- immOut_EX  out  32  registered immOut.
- PC_EX  out  32  registered PC.

Behaviour:
- Opcodes:
  - I1=0010011, I2(load)=0000011, S=0100011, R=0110011
  - BR=1100011, J=1101111, JR=1100111, U=0110111, UPC=0010111
- ALU operand A: PC for UPC, otherwise Read1.
- ALU operand B: immOut for I1/I2/S/JR/UPC; Read2 for R/BR and any other opcode.
- alu_ctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - others → 0
  - Shifts use B[4:0]. SLT/SLTU give 32'h1 or 32'h0. Arithmetic wraps modulo 2^32.
- Result mux:
  - J and JR: PC+4 (link).
  - U: immOut.
  - All other opcodes: ALU output.
- Branch decision (BR only), comparing Read1 vs Read2 independent of alu_ctrl:
  - 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
  - 010 and 011 → not taken.
- PC_src = read_data_valid & ((BR & taken) | J | JR).
- jalr = (opcode == JR). lt and ltu are continuously driven for all opcodes.
- Registered outputs (result, DataStore, immOut_EX, PC_EX):
  - Update on the rising clk edge when read_data_valid=1.
  - Hold their value when read_data_valid=0.
  - Latency is 1 cycle from input to output.
- Reset: when rst=1 at an edge, all registered outputs become 0. Reset overrides read_data_valid.
- Unknown opcode: processed as R-type path; PC_src=0.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants I1…UPC;
  - ALU control encodings;
  - branch funct3 constants.
- One sub-module, alu, is natural: combinational operands a, b and alu_ctrl in, 32-bit y out.
- Branch compare, result mux and pipeline registers stay in ex_stage.

Test Plan:
All scenarios use Read1=0x100, Read2=0xff0, immOut=0x200, PC=0xc, rd=3 unless stated.
1. Reset: rst=1 for one edge → result, DataStore, immOut_EX, PC_EX = 0.
2. R-type ADD (opcode=0110011, alu_ctrl=0000, rst=0, valid=1):
   - after one edge: result=0x10F0, DataStore=0xff0, immOut_EX=0x200, PC_EX=0xc.
   - combinational: PC_src=0, lt=1, ltu=1.
3. I-type ADD (opcode=0010011) → result=0x300 next edge; PC_src=0.
4. Branch BNE (opcode=1100011, func3=001):
   - alu_ctrl=0000: PC_src=1 immediately; result=0x10F0.
   - then alu_ctrl=0001: result=0xFFFFF110.
   - func3=000 (BEQ) → PC_src=0.
5. JAL (opcode=1101111) → PC_src=1, jalr=0, result=0x10. JALR (opcode=1100111) → PC_src=1, jalr=1, result=0x10.
6. Stall: valid=0 while inputs change → registered outputs hold previous values and PC_src=0. Asserting rst during the stall → outputs 0.
